calc_memory: RTL and testbench



---
 rtl/calc_mem_pkg.sv | 9 +
 rtl/calc_memory_if.sv | 13 +
 rtl/calc_mem_array.sv | 27 ++
 rtl/calc_memory.sv | 38 +++
 tb/tb_calc_memory.sv | 125 ++++++++++++
 5 files changed

// File: rtl/calc_mem_pkg.sv
// Shared sizing and access-type constants for the calculator data memory.
package calc_mem_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;
endpackage

// File: rtl/calc_memory_if.sv
// Access bus between the calculator control unit (master) and its data memory (slave).
interface calc_memory_if;
  import calc_mem_pkg::*;

  logic [DATA_WIDTH-1:0] Din;
  logic [ADDR_WIDTH-1:0] Addr;
  logic                  rw;
  logic                  Valid;
  logic [DATA_WIDTH-1:0] Dout;

  modport master (output Din, output Addr, output rw, output Valid, input  Dout);
  modport slave  (input  Din, input  Addr, input  rw, input  Valid, output Dout);
endinterface

// File: rtl/calc_mem_array.sv
// Storage array with synchronous clear-all and write enable; read word is combinational.
module calc_mem_array
  import calc_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/calc_memory.sv
// Calculator data memory: decodes Valid/rw and registers read data onto Dout.
module calc_memory
  import calc_mem_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  calc_memory_if.slave  bus
);

  logic                  w_we;
  logic                  w_re;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] r_dout;

  assign w_we = bus.Valid && (bus.rw == RW_WRITE);
  assign w_re = bus.Valid && (bus.rw == RW_READ);

  calc_mem_array u_array (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_addr  (bus.Addr),
    .i_wdata (bus.Din),
    .o_rdata (w_rdata)
  );

  // Dout only moves on a valid read; writes and idle cycles leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
    end else if (w_re) begin
      r_dout <= w_rdata;
    end
  end

  assign bus.Dout = r_dout;

endmodule

// File: tb/tb_calc_memory.sv
// Directed and randomized checks of calc_memory against an array-based reference model.
module tb_calc_memory;
  import calc_mem_pkg::*;

  logic clk;
  logic reset;

  calc_memory_if bus ();

  calc_memory dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] model_mem [256];
  logic [31:0] model_dout;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access, let one edge pass, advance the model, then compare Dout.
  task automatic cycle(input logic rst, input logic v, input logic w,
                       input logic [7:0] a, input logic [31:0] d, input string tag);
    reset     = rst;
    bus.Valid = v;
    bus.rw    = w;
    bus.Addr  = a;
    bus.Din   = d;
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (model_mem[i]) model_mem[i] = 32'h0;
      model_dout = 32'h0;
    end else if (v && w) begin
      model_mem[a] = d;
    end else if (v) begin
      model_dout = model_mem[a];
    end
    check(tag, bus.Dout, model_dout);
  endtask

  initial begin
    logic [7:0] addr_pool [6];
    logic       rv, rw_r, rr;
    logic [7:0] ra;
    logic [31:0] rd;

    reset     = 1'b1;
    bus.Valid = 1'b0;
    bus.rw    = RW_READ;
    bus.Addr  = 8'h00;
    bus.Din   = 32'h5;
    foreach (model_mem[i]) model_mem[i] = 32'hx;
    model_dout = 32'hx;

    cycle(1'b1, 1'b0, RW_READ,  8'h00, 32'h5, "reset_edge1");
    cycle(1'b1, 1'b0, RW_READ,  8'h00, 32'h5, "reset_edge2");
    check("reset_dout_zero", bus.Dout, 32'h0);
    cycle(1'b0, 1'b1, RW_READ,  8'h00, 32'h0, "read_after_reset");
    check("read_after_reset_zero", bus.Dout, 32'h0);

    cycle(1'b0, 1'b1, RW_WRITE, 8'h00, 32'h5, "write_holds_dout");
    check("write_no_writethrough", bus.Dout, 32'h0);
    cycle(1'b0, 1'b1, RW_READ,  8'h00, 32'h0, "read_back_5");
    check("read_back_5_const", bus.Dout, 32'h5);

    cycle(1'b0, 1'b0, RW_WRITE, 8'h00, 32'h7, "gated_write");
    cycle(1'b0, 1'b0, RW_READ,  8'h2C, 32'h0, "idle_hold");
    check("idle_hold_const", bus.Dout, 32'h5);
    cycle(1'b0, 1'b1, RW_READ,  8'h00, 32'h0, "gated_write_ignored");
    check("gated_write_ignored_const", bus.Dout, 32'h5);

    cycle(1'b0, 1'b1, RW_WRITE, 8'h2C, 32'hF00, "write_2c");
    cycle(1'b0, 1'b1, RW_READ,  8'h2C, 32'h0, "read_2c");
    check("read_2c_const", bus.Dout, 32'hF00);
    cycle(1'b0, 1'b1, RW_READ,  8'h00, 32'h0, "no_alias_00");
    check("no_alias_00_const", bus.Dout, 32'h5);

    cycle(1'b0, 1'b1, RW_WRITE, 8'hFF, 32'hDEADBEEF, "write_ff");
    cycle(1'b0, 1'b1, RW_WRITE, 8'h00, 32'h12345678, "write_00");
    cycle(1'b0, 1'b1, RW_READ,  8'hFF, 32'h0, "read_ff");
    check("read_ff_const", bus.Dout, 32'hDEADBEEF);
    cycle(1'b0, 1'b1, RW_READ,  8'h00, 32'h0, "read_00");
    check("read_00_const", bus.Dout, 32'h12345678);
    cycle(1'b0, 1'b1, RW_READ,  8'h80, 32'h0, "read_unwritten_80");
    check("read_unwritten_80_const", bus.Dout, 32'h0);
    cycle(1'b0, 1'b1, RW_READ,  8'hFF, 32'h0, "reread_ff");

    cycle(1'b1, 1'b1, RW_WRITE, 8'h2C, 32'hAAAA5555, "mid_reset");
    check("mid_reset_const", bus.Dout, 32'h0);
    cycle(1'b0, 1'b1, RW_READ,  8'h2C, 32'h0, "post_reset_2c");
    check("post_reset_2c_const", bus.Dout, 32'h0);
    cycle(1'b0, 1'b1, RW_READ,  8'hFF, 32'h0, "post_reset_ff");
    check("post_reset_ff_const", bus.Dout, 32'h0);
    cycle(1'b0, 1'b1, RW_READ,  8'h00, 32'h0, "post_reset_00");
    check("post_reset_00_const", bus.Dout, 32'h0);

    // Random traffic over a small address pool so reads often hit earlier writes.
    addr_pool[0] = 8'h00; addr_pool[1] = 8'hFF; addr_pool[2] = 8'h2C;
    addr_pool[3] = 8'h80; addr_pool[4] = 8'h01; addr_pool[5] = 8'hFE;
    for (int n = 0; n < 400; n++) begin
      rr   = ($urandom_range(0, 59) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      rw_r = $urandom_range(0, 1);
      ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 5)];
      rd   = $urandom;
      cycle(rr, rv, rw_r, ra, rd, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
